// File: rtl/axi_lite_pkg.sv
// Shared constants, read-FSM encoding and byte-strobe merge helper for the
// AXI4-Lite VRAM responder.
package axi_lite_pkg;

  localparam int NUM_WORDS_DEF = 601;
  localparam int CTRL_INDEX    = NUM_WORDS_DEF - 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE  = 2'b00,
    R_FETCH = 2'b01,
    R_VALID = 2'b10
  } rstate_e;

  // Lanes with a set strobe take the new byte; the rest keep the old one.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_vram_responder_if.sv
// AXI4-Lite bus bundle between the MicroBlaze interconnect and the VRAM
// responder; master drives requests, slave drives ready/responses.
interface axi_lite_vram_responder_if #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16
);

  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr;
  logic [2:0]                    axi_awprot;
  logic                          axi_awvalid;
  logic                          axi_awready;
  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata;
  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb;
  logic                          axi_wvalid;
  logic                          axi_wready;
  logic [1:0]                    axi_bresp;
  logic                          axi_bvalid;
  logic                          axi_bready;
  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr;
  logic [2:0]                    axi_arprot;
  logic                          axi_arvalid;
  logic                          axi_arready;
  logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata;
  logic [1:0]                    axi_rresp;
  logic                          axi_rvalid;
  logic                          axi_rready;

  modport master (
    output axi_awaddr, axi_awprot, axi_awvalid,
    output axi_wdata, axi_wstrb, axi_wvalid,
    output axi_bready,
    output axi_araddr, axi_arprot, axi_arvalid,
    output axi_rready,
    input  axi_awready, axi_wready,
    input  axi_bresp, axi_bvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid
  );

  modport slave (
    input  axi_awaddr, axi_awprot, axi_awvalid,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_bready,
    input  axi_araddr, axi_arprot, axi_arvalid,
    input  axi_rready,
    output axi_awready, axi_wready,
    output axi_bresp, axi_bvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid
  );

endinterface

// File: rtl/axi_lite_vram_responder_vram_regfile.sv
// VRAM word array plus the reset-cleared control word, with a byte-strobed
// write port, an enabled AXI read port and a free-running video read port.
module vram_regfile
  import axi_lite_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int IDX_W     = 14
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic [31:0]      rdata_o,
  input  logic [9:0]       vidx_i,
  output logic [31:0]      vdata_o,
  output logic [31:0]      ctrl_o
);

  localparam int DEPTH = NUM_WORDS - 1;
  localparam int MW    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] CTRL_A = IDX_W'(DEPTH);
  localparam logic [9:0]       CTRL_V = 10'(DEPTH);

  logic [31:0] mem_q [0:DEPTH-1];
  logic [31:0] ctrl_q;
  logic [31:0] rdata_q;
  logic [31:0] vdata_q;
  logic [31:0] rsel_d;
  logic [31:0] vsel_d;

  // VRAM write port; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i && (widx_i < CTRL_A)) begin
      mem_q[widx_i[MW-1:0]] <= apply_strb(mem_q[widx_i[MW-1:0]], wdata_i, wstrb_i);
    end
  end

  // Control word sits after the VRAM and clears on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrl_q <= 32'h0000_0000;
    end else if (we_i && (widx_i == CTRL_A)) begin
      ctrl_q <= apply_strb(ctrl_q, wdata_i, wstrb_i);
    end
  end

  // Word select for both read ports; holes above the control word read zero.
  always_comb begin
    rsel_d = 32'h0000_0000;
    vsel_d = 32'h0000_0000;
    if (ridx_i < CTRL_A) begin
      rsel_d = mem_q[ridx_i[MW-1:0]];
    end else if (ridx_i == CTRL_A) begin
      rsel_d = ctrl_q;
    end else begin
      rsel_d = 32'h0000_0000;
    end
    if (vidx_i < CTRL_V) begin
      vsel_d = mem_q[vidx_i[MW-1:0]];
    end else if (vidx_i == CTRL_V) begin
      vsel_d = ctrl_q;
    end else begin
      vsel_d = 32'h0000_0000;
    end
  end

  // Registered read ports: AXI samples only when asked, video every cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= 32'h0000_0000;
      vdata_q <= 32'h0000_0000;
    end else begin
      if (re_i) begin
        rdata_q <= rsel_d;
      end
      vdata_q <= vsel_d;
    end
  end

  assign rdata_o = rdata_q;
  assign vdata_o = vdata_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/axi_lite_vram_responder.sv
// AXI4-Lite responder for the text-mode HDMI VRAM: independent AW/W latches
// with a single B response, and a three-state read FSM feeding the R channel.
module axi_lite_vram_responder
  import axi_lite_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int NUM_WORDS        = NUM_WORDS_DEF
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  axi_lite_vram_responder_if.slave s_axi,
  input  logic [9:0]  vram_raddr,
  output logic [31:0] vram_rdata,
  output logic [31:0] ctrl_reg
);

  localparam int IDX_W = C_AXI_ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] NUM_A = IDX_W'(NUM_WORDS);

  logic                          aw_full_q, aw_full_d;
  logic [IDX_W-1:0]              aw_idx_q, aw_idx_d;
  logic                          w_full_q, w_full_d;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [C_AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                          awready_q, awready_d;
  logic                          wready_q, wready_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;

  rstate_e                       rstate_q, rstate_d;
  logic [IDX_W-1:0]              ar_idx_q, ar_idx_d;
  logic                          arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  logic [C_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;

  logic        aw_hs_s, w_hs_s, commit_s, b_done_s, aw_ok_s, ar_ok_s, rd_en_s;
  logic [31:0] rd_data_s;
  logic        unused_s;

  assign aw_hs_s  = s_axi.axi_awvalid & awready_q;
  assign w_hs_s   = s_axi.axi_wvalid & wready_q;
  assign commit_s = aw_full_q & w_full_q;
  assign b_done_s = bvalid_q & s_axi.axi_bready;
  assign aw_ok_s  = (aw_idx_q < NUM_A);
  assign ar_ok_s  = (ar_idx_q < NUM_A);
  assign rd_en_s  = (rstate_q == R_FETCH);

  // Write channel next state: latches fill independently, drain together on commit.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (commit_s) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs_s) begin
        aw_full_d = 1'b1;
        aw_idx_d  = s_axi.axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
      end else begin
        aw_full_d = aw_full_q;
      end
      if (w_hs_s) begin
        w_full_d = 1'b1;
        wdata_d  = s_axi.axi_wdata;
        wstrb_d  = s_axi.axi_wstrb;
      end else begin
        w_full_d = w_full_q;
      end
      if (b_done_s) begin
        bvalid_d = 1'b0;
      end else begin
        bvalid_d = bvalid_q;
      end
    end
    awready_d = ~aw_full_d & ~bvalid_d;
    wready_d  = ~w_full_d & ~bvalid_d;
  end

  // Write channel registers.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read FSM: the regfile samples during R_FETCH, R_VALID then presents it.
  always_comb begin
    rstate_d = rstate_q;
    ar_idx_d = ar_idx_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (s_axi.axi_arvalid && arready_q) begin
          rstate_d = R_FETCH;
          ar_idx_d = s_axi.axi_araddr[C_AXI_ADDR_WIDTH-1:2];
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_FETCH: rstate_d = R_VALID;
      R_VALID: begin
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
          rdata_d  = C_AXI_DATA_WIDTH'(rd_data_s);
          rresp_d  = ar_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi.axi_rready) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end else begin
          rstate_d = R_VALID;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  // Read channel registers.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      rstate_q  <= R_IDLE;
      ar_idx_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      rstate_q  <= rstate_d;
      ar_idx_q  <= ar_idx_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  vram_regfile #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .clk_i   (axi_aclk),
    .rst_ni  (axi_aresetn),
    .we_i    (commit_s & aw_ok_s),
    .widx_i  (aw_idx_q),
    .wdata_i (32'(wdata_q)),
    .wstrb_i (4'(wstrb_q)),
    .re_i    (rd_en_s),
    .ridx_i  (ar_idx_q),
    .rdata_o (rd_data_s),
    .vidx_i  (vram_raddr),
    .vdata_o (vram_rdata),
    .ctrl_o  (ctrl_reg)
  );

  assign s_axi.axi_awready = awready_q;
  assign s_axi.axi_wready  = wready_q;
  assign s_axi.axi_bvalid  = bvalid_q;
  assign s_axi.axi_bresp   = bresp_q;
  assign s_axi.axi_arready = arready_q;
  assign s_axi.axi_rvalid  = rvalid_q;
  assign s_axi.axi_rdata   = rdata_q;
  assign s_axi.axi_rresp   = rresp_q;

  // Protection bits and byte offsets carry no meaning for this aligned slave.
  assign unused_s = ^{s_axi.axi_awprot, s_axi.axi_arprot,
                      s_axi.axi_awaddr[1:0], s_axi.axi_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_vram_responder.sv
// Self-checking bench: directed plan plus random AXI traffic against a
// word-array reference model of the VRAM and control register.
module tb_axi_lite_vram_responder;
  import axi_lite_pkg::*;

  logic        axi_aclk    = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic [9:0]  vram_raddr  = 10'd0;
  logic [31:0] vram_rdata;
  logic [31:0] ctrl_reg;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [0:600];

  axi_lite_vram_responder_if #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(16)) bus ();

  axi_lite_vram_responder #(
    .C_AXI_DATA_WIDTH (32),
    .C_AXI_ADDR_WIDTH (16),
    .NUM_WORDS        (601)
  ) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .s_axi       (bus),
    .vram_raddr  (vram_raddr),
    .vram_rdata  (vram_rdata),
    .ctrl_reg    (ctrl_reg)
  );

  always #5 axi_aclk = ~axi_aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] mask = 32'h0;
    for (int i = 0; i < 4; i++) if (strb[i]) mask = mask | (32'hFF << (8 * i));
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    return (idx < 601) ? model[idx] : 32'h0;
  endfunction

  function automatic logic [1:0] model_resp(input int idx);
    return (idx < 601) ? 2'b00 : 2'b10;
  endfunction

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    int idx;
    int n;
    logic [1:0] resp_e;
    idx = int'(addr[15:2]);
    resp_e = model_resp(idx);
    fork
      begin
        int k;
        repeat (aw_dly) cyc();
        bus.axi_awaddr  = addr;
        bus.axi_awprot  = 3'($urandom);
        bus.axi_awvalid = 1'b1;
        k = 0;
        while (bus.axi_awready !== 1'b1 && k < 50) begin cyc(); k++; end
        if (k >= 50) chk("aw_timeout", 32'(bus.axi_awready), 32'd1);
        cyc();
        bus.axi_awvalid = 1'b0;
      end
      begin
        int k;
        repeat (w_dly) cyc();
        bus.axi_wdata  = data;
        bus.axi_wstrb  = strb;
        bus.axi_wvalid = 1'b1;
        k = 0;
        while (bus.axi_wready !== 1'b1 && k < 50) begin cyc(); k++; end
        if (k >= 50) chk("w_timeout", 32'(bus.axi_wready), 32'd1);
        cyc();
        bus.axi_wvalid = 1'b0;
      end
    join
    n = 0;
    while (bus.axi_bvalid !== 1'b1 && n < 50) begin cyc(); n++; end
    chk("b_valid", 32'(bus.axi_bvalid), 32'd1);
    if (idx < 601) model[idx] = merge(model[idx], data, strb);
    chk("bresp", 32'(bus.axi_bresp), 32'(resp_e));
    for (int i = 0; i < b_dly; i++) begin
      cyc();
      chk("b_hold_valid", 32'(bus.axi_bvalid), 32'd1);
      chk("b_hold_resp", 32'(bus.axi_bresp), 32'(resp_e));
      chk("b_hold_awready", 32'(bus.axi_awready), 32'd0);
      chk("b_hold_wready", 32'(bus.axi_wready), 32'd0);
    end
    bus.axi_bready = 1'b1;
    cyc();
    bus.axi_bready = 1'b0;
    chk("b_clear", 32'(bus.axi_bvalid), 32'd0);
    chk("awready_after_b", 32'(bus.axi_awready), 32'd1);
    chk("wready_after_b", 32'(bus.axi_wready), 32'd1);
    chk("ctrl_reg", ctrl_reg, model[600]);
  endtask

  task automatic axi_read(input logic [15:0] addr, input int r_dly, input logic [9:0] vidx);
    int idx;
    int k;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    idx   = int'(addr[15:2]);
    exp_d = model_read(idx);
    exp_r = model_resp(idx);
    bus.axi_araddr  = addr;
    bus.axi_arprot  = 3'($urandom);
    bus.axi_arvalid = 1'b1;
    k = 0;
    while (bus.axi_arready !== 1'b1 && k < 50) begin cyc(); k++; end
    if (k >= 50) chk("ar_timeout", 32'(bus.axi_arready), 32'd1);
    cyc();
    bus.axi_arvalid = 1'b0;
    chk("r_lat_n1", 32'(bus.axi_rvalid), 32'd0);
    cyc();
    chk("r_lat_n2", 32'(bus.axi_rvalid), 32'd0);
    cyc();
    chk("r_valid", 32'(bus.axi_rvalid), 32'd1);
    chk("rdata", bus.axi_rdata, exp_d);
    chk("rresp", 32'(bus.axi_rresp), 32'(exp_r));
    vram_raddr = vidx;
    for (int i = 0; i < r_dly; i++) begin
      cyc();
      chk("r_hold_valid", 32'(bus.axi_rvalid), 32'd1);
      chk("r_hold_data", bus.axi_rdata, exp_d);
      chk("video_rdata", vram_rdata, model_read(int'(vidx)));
    end
    bus.axi_rready = 1'b1;
    cyc();
    bus.axi_rready = 1'b0;
    chk("r_clear", 32'(bus.axi_rvalid), 32'd0);
    chk("arready_after_r", 32'(bus.axi_arready), 32'd1);
    chk("video_rdata_end", vram_rdata, model_read(int'(vidx)));
  endtask

  initial begin
    int idx;
    bus.axi_awaddr = '0; bus.axi_awprot = '0; bus.axi_awvalid = 1'b0;
    bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wvalid = 1'b0;
    bus.axi_bready = 1'b0;
    bus.axi_araddr = '0; bus.axi_arprot = '0; bus.axi_arvalid = 1'b0;
    bus.axi_rready = 1'b0;

    axi_aresetn = 1'b0;
    repeat (3) cyc();
    chk("rst_awready", 32'(bus.axi_awready), 32'd0);
    chk("rst_wready", 32'(bus.axi_wready), 32'd0);
    chk("rst_arready", 32'(bus.axi_arready), 32'd0);
    chk("rst_bvalid", 32'(bus.axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.axi_rvalid), 32'd0);
    chk("rst_bresp", 32'(bus.axi_bresp), 32'd0);
    chk("rst_rresp", 32'(bus.axi_rresp), 32'd0);
    chk("rst_rdata", bus.axi_rdata, 32'd0);
    chk("rst_ctrl", ctrl_reg, 32'd0);
    axi_aresetn = 1'b1;
    model[CTRL_INDEX] = 32'h0;
    cyc();

    for (int i = 0; i < 600; i++) axi_write(16'(i * 4), $urandom, 4'hF, 0, 0, 0);

    axi_write(16'h0960, 32'h001F_6000, 4'hF, 0, 0, 0);
    chk("plan_ctrl", ctrl_reg, 32'h001F_6000);
    axi_read(16'h0960, 0, 10'd0);

    axi_write(16'h0014, 32'h1122_3344, 4'hF, 0, 3, 0);
    axi_write(16'h0014, 32'h0000_AB00, 4'b0010, 2, 0, 0);
    chk("plan_word5", model[5], 32'h1122_AB44);
    axi_read(16'h0014, 0, 10'd5);

    axi_write(16'h0964, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    axi_read(16'h0964, 0, 10'd5);

    axi_write(16'h0020, 32'hCAFE_F00D, 4'hF, 1, 0, 5);
    axi_read(16'h0018, 4, 10'd5);
    axi_read(16'h095C, 1, 10'd599);
    axi_read(16'hFFFC, 1, 10'd1023);

    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) == 0) idx = $urandom_range(601, 16383);
      else idx = $urandom_range(0, 600);
      if ($urandom_range(0, 1) == 0)
        axi_write({14'(idx), 2'($urandom)}, $urandom, 4'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read({14'(idx), 2'($urandom)}, $urandom_range(0, 3), 10'($urandom_range(0, 1023)));
    end

    bus.axi_awaddr  = 16'h0030;
    bus.axi_awvalid = 1'b1;
    idx = 0;
    while (bus.axi_awready !== 1'b1 && idx < 50) begin cyc(); idx++; end
    cyc();
    bus.axi_awvalid = 1'b0;
    axi_aresetn = 1'b0;
    cyc();
    axi_aresetn = 1'b1;
    model[CTRL_INDEX] = 32'h0;
    chk("rst2_awready", 32'(bus.axi_awready), 32'd0);
    chk("rst2_ctrl", ctrl_reg, 32'd0);
    cyc();
    chk("rst2_awready_rel", 32'(bus.axi_awready), 32'd1);
    chk("rst2_wready_rel", 32'(bus.axi_wready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rst2_no_b", 32'(bus.axi_bvalid), 32'd0);
    end
    axi_write(16'h0030, 32'h5A5A_1234, 4'hF, 1, 0, 0);
    axi_read(16'h0030, 0, 10'd12);
    axi_read(16'h0960, 0, 10'd600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_vram_responder.md
Name: axi_lite_vram_responder

Overview:
AXI4-Lite slave (responder) that terminates the MicroBlaze register bus for the text-mode HDMI path. It holds the 600-word VRAM plus one control register (word 600). It exposes a synchronous read port and the control word to the pixel/draw logic. It has independent write-address and write-data handshakes and honours byte write strobes for the driver's byte/halfword stores.

Parameters:
C_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
C_AXI_ADDR_WIDTH, 16, byte address width; word index = addr[C_AXI_ADDR_WIDTH-1:2]
NUM_WORDS, 601, implemented words; index NUM_WORDS-1 is the control register

Ports:
axi_aclk  in  1  sole clock
axi_aresetn  in  1  reset, synchronous, active-low
axi_awaddr  in  C_AXI_ADDR_WIDTH  write address
axi_awprot  in  3  ignored
axi_awvalid / axi_awready  in / out  1  AW handshake
axi_wdata  in  32  write data
axi_wstrb  in  4  byte enables
axi_wvalid / axi_wready  in / out  1  W handshake
axi_bresp  out  2  write response
axi_bvalid / axi_bready  out / in  1  B handshake
axi_araddr  in  C_AXI_ADDR_WIDTH  read address
axi_arprot  in  3  ignored
axi_arvalid / axi_arready  in / out  1  AR handshake
axi_rdata  out  32  read data
axi_rresp  out  2  read response
axi_rvalid / axi_rready  out / in  1  R handshake
vram_raddr  in  10  video-side word index
vram_rdata  out  32  video-side data, registered, 1-cycle latency
ctrl_reg  out  32  live control register (word NUM_WORDS-1)

Behaviour:
- Reset (axi_aresetn=0 at an edge): all ready/valid outputs 0, bresp/rresp/rdata 0, AW/W latches cleared, ctrl_reg 0. VRAM contents are not cleared. Reset aborts any in-flight transaction without a response.
- Write path: awready=1 when no address is latched and bvalid=0. wready=1 when no data is latched and bvalid=0. Each channel handshakes independently, in either order or the same cycle, and latches addr or data+strb.
- Write commit: on the first edge where both are latched, bytes with wstrb[i]=1 are written and the others are kept. At that edge bvalid is set and both latches clear. bvalid holds until the bready edge. No new AW/W is accepted while bvalid=1.
- Out-of-range (index >= NUM_WORDS): no write; bresp=SLVERR (2'b10). Otherwise OKAY (2'b00).
- Read FSM: R_IDLE (arready=1) -> on arvalid edge, latch index -> R_FETCH (1 cycle, memory sampled) -> R_VALID (rvalid=1, rdata/rresp stable) -> on rready edge -> R_IDLE. AR handshake edge N gives rvalid first high after edge N+2.
- Out-of-range read: rdata=0, rresp=SLVERR.
- Same-word collision: if a write commits on the R_FETCH sample edge, the read returns the pre-write value. A read whose AR handshake follows the B-channel set edge returns the new value.
- Read and write paths are fully concurrent; neither stalls the other.
- Video port: vram_rdata <= mem[vram_raddr] every cycle, unaffected by AXI traffic. Index >= NUM_WORDS returns 0.
- Address bits [1:0] are ignored (aligned access only). awprot/arprot are ignored.

Decomposition:
- Package axi_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, read FSM enum (R_IDLE, R_FETCH, R_VALID), NUM_WORDS default, CTRL_INDEX.
- Sub-module vram_regfile: byte-strobed write port, AXI read port, video read port, ctrl_reg tap. The top keeps only the handshake and FSM logic.

Test Plan:
- AW and W same cycle to 0x0960 with data 0x001F6000, strb F -> BRESP OKAY; ctrl_reg=0x001F6000; read of 0x0960 returns 0x001F6000, OKAY.
- AW presented 3 cycles before W (addr 0x0014, data 0x11223344); then W before AW by 2 cycles, same address, data 0x0000AB00, strb 4'b0010 -> one B per write; read of word 5 = 0x1122AB44.
- Write to 0x0964 (index 601) -> BRESP SLVERR, no memory change; read of 0x0964 -> rdata 0, rresp SLVERR.
- bready held low 5 cycles after commit -> bvalid and bresp stable, awready=wready=0 throughout, next write accepted the cycle after the B handshake.
- Read with rready low 4 cycles -> rvalid held, rdata stable. Meanwhile vram_raddr=5 gives vram_rdata=0x1122AB44 one cycle later.
- Assert axi_aresetn=0 for one edge between AW and W handshakes -> no B response. After release the next full write completes normally and ctrl_reg reads 0.
